cordic_result_buf: RTL and testbench

Result-capture buffer downstream of the IEEE-754 CORDIC wrapper. It edge-detects the wrapper's level-style `valid` and snapshots the three IEEE-754 results (e^x, sinh x, cosh x) as one entry into a small FIFO. It presents entries to the consumer over a ready/valid handshake, each tagged with a sequence number. Results arriving while the FIFO is full are dropped and counted, never overwritten.

---
 rtl/cordic_result_buf_pkg.sv | 20 ++
 rtl/cordic_resbuf_fifo.sv | 53 +++++
 rtl/cordic_result_buf.sv | 119 +++++++++++
 tb/tb_cordic_result_buf.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_result_buf_pkg.sv
// Shared types and helpers for the CORDIC result-capture buffer.
package cordic_result_buf_pkg;

  // Widest supported sequence tag; narrower tags are zero-extended into the entry.
  localparam int unsigned SEQ_W_MAX = 32;

  localparam logic [7:0] IEEE_EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic [31:0]          epx;
    logic [31:0]          sinhx;
    logic [31:0]          coshx;
    logic [SEQ_W_MAX-1:0] seq;
  } entry_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (w[30:23] == IEEE_EXP_ALL_ONES) && (w[22:0] != '0);
  endfunction

endpackage

// File: rtl/cordic_resbuf_fifo.sv
// Circular storage with wrap-around pointers and an occupancy counter.
module cordic_resbuf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/cordic_result_buf.sv
// Captures each rising edge of the CORDIC wrapper's valid level into a tagged FIFO.
// Optional per-entry NaN flag and out_nan port: define CORDIC_RESBUF_NAN_FLAG_EN.
module cordic_result_buf
  import cordic_result_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_epx,
  input  logic [31:0]            in_sinhx,
  input  logic [31:0]            in_coshx,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_epx,
  output logic [31:0]            out_sinhx,
  output logic [31:0]            out_coshx,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic [SEQ_W-1:0]       drop_cnt,
  output logic                   overflow
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
  ,
  output logic                   out_nan
`endif
);

  localparam int unsigned EW = $bits(entry_t);
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
  localparam int unsigned W = EW + 1;
`else
  localparam int unsigned W = EW;
`endif

  logic             in_valid_q;
  logic [SEQ_W-1:0] seq;
  logic             cap;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;
  entry_t           wr_entry;
  entry_t           head;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     rd_data;

  assign cap       = in_valid & ~in_valid_q;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & ~flush;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push      = cap & ~flush & (~full | pop);
  assign drop      = cap & ~flush & full & ~pop;

  always_comb begin
    wr_entry       = '0;
    wr_entry.epx   = in_epx;
    wr_entry.sinhx = in_sinhx;
    wr_entry.coshx = in_coshx;
    wr_entry.seq   = SEQ_W_MAX'(seq);
  end

`ifdef CORDIC_RESBUF_NAN_FLAG_EN
  assign wr_data = {is_nan(in_epx) | is_nan(in_sinhx) | is_nan(in_coshx), wr_entry};
  assign out_nan = out_valid & rd_data[W-1];
`else
  assign wr_data = wr_entry;
`endif

  assign head = rd_data[EW-1:0];

  // Words are gated so an empty buffer (including just after reset) shows zeros.
  assign out_epx   = out_valid ? head.epx   : '0;
  assign out_sinhx = out_valid ? head.sinhx : '0;
  assign out_coshx = out_valid ? head.coshx : '0;
  assign out_seq   = out_valid ? SEQ_W'(head.seq) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_q <= 1'b0;
      seq        <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (flush) begin
        seq      <= '0;
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (cap) seq <= seq + SEQ_W'(1);
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != '1) drop_cnt <= drop_cnt + SEQ_W'(1);
        end
      end
    end
  end

  cordic_resbuf_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_cordic_result_buf.sv
// Randomized and directed bench for cordic_result_buf against a queue-based model.
module tb_cordic_result_buf;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SEQ_W = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned SEQ_M = 1 << SEQ_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_epx, in_sinhx, in_coshx;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_epx, out_sinhx, out_coshx;
  logic [SEQ_W-1:0] out_seq;
  logic [CW-1:0]    count;
  logic [SEQ_W-1:0] drop_cnt;
  logic             overflow;
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
  logic             out_nan;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    logic [31:0] e, s, c;
    int unsigned sq;
    bit          nan;
  } ment_t;

  ment_t       q[$];
  int unsigned m_seq, m_drop;
  bit          m_ovf, m_prev;

  always #5 clk = ~clk;

  cordic_result_buf #(
    .DEPTH (DEPTH),
    .SEQ_W (SEQ_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_epx    (in_epx),
    .in_sinhx  (in_sinhx),
    .in_coshx  (in_coshx),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_epx   (out_epx),
    .out_sinhx (out_sinhx),
    .out_coshx (out_coshx),
    .out_seq   (out_seq),
    .count     (count),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
    ,
    .out_nan   (out_nan)
`endif
  );

  function automatic bit ref_nan(input logic [31:0] w);
    return (((w >> 23) & 32'hFF) == 32'hFF) && ((w & 32'h007F_FFFF) != 0);
  endfunction

  task automatic model_clear();
    q.delete();
    m_seq  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  // Advance one clock; the model applies the rules to the inputs seen at the edge.
  task automatic tick();
    bit    cap, pop, full, v;
    ment_t ent;
    cap = in_valid && !m_prev;
    pop = (q.size() != 0) && out_ready;
    full = (q.size() == DEPTH);
    v = in_valid;
    ent.e = in_epx; ent.s = in_sinhx; ent.c = in_coshx; ent.sq = m_seq;
    ent.nan = ref_nan(in_epx) || ref_nan(in_sinhx) || ref_nan(in_coshx);
    @(posedge clk);
    if (!rst) begin
      model_clear();
      m_prev = 0;
    end else begin
      if (flush) model_clear();
      else begin
        if (pop) void'(q.pop_front());
        if (cap) begin
          if (!full || pop) q.push_back(ent);
          else begin
            if (m_drop < SEQ_M - 1) m_drop++;
            m_ovf = 1;
          end
          m_seq = (m_seq + 1) % SEQ_M;
        end
      end
      m_prev = v;
    end
    #1;
  endtask

  task automatic set_words(input logic [31:0] e, input logic [31:0] s, input logic [31:0] c);
    in_epx = e; in_sinhx = s; in_coshx = c;
  endtask

  task automatic do_flush();
    flush = 1; tick(); flush = 0;
  endtask

  task automatic test_reset();
    rst = 0; in_valid = 0; flush = 0; out_ready = 0;
    set_words(32'h0, 32'h0, 32'h0);
    #2;
    repeat (3) tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    vectors++; if (drop_cnt !== '0 || overflow !== 1'b0) begin miscompares++; $display("FAIL reset_drop got %0d/%b exp 0/0", drop_cnt, overflow); end
    vectors++; if (out_epx !== '0 || out_seq !== '0) begin miscompares++; $display("FAIL reset_words got %h/%0d exp 0/0", out_epx, out_seq); end
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
    vectors++; if (out_nan !== 1'b0) begin miscompares++; $display("FAIL reset_nan got %b exp 0", out_nan); end
`endif
    rst = 1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1;
    set_words(32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000);
    in_valid = 1;
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b exp 1", out_valid); end
    vectors++; if ({out_epx, out_sinhx, out_coshx} !== {32'h3F80_0000, 32'h0, 32'h3F80_0000})
      begin miscompares++; $display("FAIL single_words got %h %h %h exp 3f800000 00000000 3f800000", out_epx, out_sinhx, out_coshx); end
    vectors++; if (out_seq !== 8'd0) begin miscompares++; $display("FAIL single_seq got %0d exp 0", out_seq); end
    tick();
    vectors++; if (count !== CW'(0)) begin miscompares++; $display("FAIL single_count got %0d exp 0", count); end
    in_valid = 0; out_ready = 0;
    tick();
  endtask

  task automatic test_hold();
    in_valid = 1;
    repeat (20) tick();
    vectors++; if (count !== CW'(1) || q.size() != 1) begin miscompares++; $display("FAIL hold_count got %0d exp 1", count); end
    vectors++; if (out_seq !== 8'd1) begin miscompares++; $display("FAIL hold_seq got %0d exp 1", out_seq); end
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_overflow();
    do_flush();
    set_words(32'h402D_F854, 32'h3F96_6CFE, 32'h3FC5_83AB);
    repeat (DEPTH + 2) begin in_valid = 1; tick(); in_valid = 0; tick(); end
    vectors++; if (count !== CW'(DEPTH)) begin miscompares++; $display("FAIL ovf_count got %0d exp %0d", count, DEPTH); end
    vectors++; if (drop_cnt !== 8'd2) begin miscompares++; $display("FAIL ovf_drop got %0d exp 2", drop_cnt); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_seq !== SEQ_W'(i))
        begin miscompares++; $display("FAIL drain_seq got %b/%0d exp 1/%0d", out_valid, out_seq, i); end
      vectors++; if ({out_epx, out_sinhx, out_coshx} !== {32'h402D_F854, 32'h3F96_6CFE, 32'h3FC5_83AB})
        begin miscompares++; $display("FAIL drain_words got %h %h %h", out_epx, out_sinhx, out_coshx); end
      tick();
    end
    out_ready = 0;
    vectors++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin miscompares++; $display("FAIL drained got %b/%b exp 0/1", out_valid, overflow); end
  endtask

  task automatic test_full_pop();
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      set_words($urandom(), $urandom(), $urandom());
      in_valid = 1; tick(); in_valid = 0; tick();
    end
    set_words(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    vectors++; if (count !== CW'(DEPTH)) begin miscompares++; $display("FAIL fullpop_count got %0d exp %0d", count, DEPTH); end
    vectors++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL fullpop_drop got %0d/%b exp 0/0", drop_cnt, overflow); end
    vectors++; if (out_seq !== 8'd1) begin miscompares++; $display("FAIL fullpop_head got %0d exp 1", out_seq); end
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      vectors++; if (out_seq !== SEQ_W'(q[0].sq) || {out_epx, out_sinhx, out_coshx} !== {q[0].e, q[0].s, q[0].c})
        begin miscompares++; $display("FAIL fullpop_drain got %0d %h exp %0d %h", out_seq, out_epx, q[0].sq, q[0].e); end
      tick();
    end
    out_ready = 0;
    vectors++; if (m_seq != 5 || out_valid !== 1'b0) begin miscompares++; $display("FAIL fullpop_end got %b exp 0", out_valid); end
  endtask

  task automatic test_saturate();
    do_flush();
    set_words(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    repeat (DEPTH + 260) begin in_valid = 1; tick(); in_valid = 0; tick(); end
    vectors++; if (drop_cnt !== 8'hFF) begin miscompares++; $display("FAIL sat_drop got %0d exp 255", drop_cnt); end
    out_ready = 1;
    repeat (DEPTH) tick();
    out_ready = 0;
    in_valid = 1; tick(); in_valid = 0; tick();
    vectors++; if (out_seq !== 8'd8) begin miscompares++; $display("FAIL sat_seq_wrap got %0d exp 8", out_seq); end
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      set_words($urandom(), $urandom(), $urandom());
      in_valid = 1; tick(); in_valid = 0; tick();
    end
    vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL mid_count got %0d exp 3", count); end
    in_valid = 1;
    #2 rst = 0;
    #1;
    vectors++; if (out_valid !== 1'b0 || count !== '0 || out_epx !== '0 || out_seq !== '0)
      begin miscompares++; $display("FAIL mid_async got %b/%0d/%h/%0d exp 0/0/0/0", out_valid, count, out_epx, out_seq); end
    model_clear(); m_prev = 0;
    tick(); tick();
    rst = 1;
    tick();
    vectors++; if (out_valid !== 1'b1 || out_seq !== 8'd0 || count !== CW'(1))
      begin miscompares++; $display("FAIL release_cap got %b/%0d/%0d exp 1/0/1", out_valid, out_seq, count); end
    in_valid = 0; out_ready = 1; tick(); out_ready = 0;
  endtask

`ifdef CORDIC_RESBUF_NAN_FLAG_EN
  task automatic test_nan();
    do_flush();
    set_words(32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000);
    in_valid = 1; tick(); in_valid = 0;
    vectors++; if (out_nan !== 1'b1) begin miscompares++; $display("FAIL nan_qnan got %b exp 1", out_nan); end
    out_ready = 1; tick(); out_ready = 0;
    set_words(32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000);
    in_valid = 1; tick(); in_valid = 0;
    vectors++; if (out_nan !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL nan_inf got %b exp 0", out_nan); end
    out_ready = 1; tick(); out_ready = 0;
  endtask
`endif

  task automatic test_random();
    logic [31:0] w[3];
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 3; k++) begin
        w[k] = $urandom();
        if ($urandom_range(0, 5) == 0) w[k][30:23] = 8'hFF;
      end
      set_words(w[0], w[1], w[2]);
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 4);
      flush     = ($urandom_range(0, 60) == 0);
      tick();
      vectors++; if (out_valid !== (q.size() != 0) || count !== CW'(q.size()))
        begin miscompares++; $display("FAIL rnd_occ cyc %0d got %b/%0d exp %0d", n, out_valid, count, q.size()); end
      vectors++; if (drop_cnt !== SEQ_W'(m_drop) || overflow !== m_ovf)
        begin miscompares++; $display("FAIL rnd_drop cyc %0d got %0d/%b exp %0d/%b", n, drop_cnt, overflow, m_drop, m_ovf); end
      if (q.size() != 0) begin
        vectors++; if ({out_epx, out_sinhx, out_coshx} !== {q[0].e, q[0].s, q[0].c} || out_seq !== SEQ_W'(q[0].sq))
          begin miscompares++; $display("FAIL rnd_head cyc %0d got %h %h %h %0d exp %h %h %h %0d", n, out_epx, out_sinhx, out_coshx, out_seq, q[0].e, q[0].s, q[0].c, q[0].sq); end
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
        vectors++; if (out_nan !== q[0].nan) begin miscompares++; $display("FAIL rnd_nan cyc %0d got %b exp %b", n, out_nan, q[0].nan); end
`endif
      end
    end
    flush = 0; in_valid = 0; out_ready = 0;
  endtask

  initial begin
    m_prev = 0;
    model_clear();
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_reset_mid();
`ifdef CORDIC_RESBUF_NAN_FLAG_EN
    test_nan();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
